// File: rtl/instr_fetch_stage_pkg.sv
// Shared fetch definitions: FSM state encoding, NOP word, PC step and
// the ROM window check used by the PC generator.
package instr_fetch_stage_pkg;

    // Encoding is shared with decode, so the values are pinned.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC      = 32'd4;

    // True when addr lies in [base, base + 4*words).
    function automatic logic pc_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned words
    );
        logic [31:0] off;
        logic [31:0] span;
        off  = addr - base;
        span = 32'(words) << 2;
        return (addr >= base) && (off < span);
    endfunction

endpackage

// File: rtl/instr_fetch_stage_pc_gen.sv
// Combinational next-PC mux plus range and alignment checks.
// Ports: pc/stall/redirect in; next_pc, pc_ok, redir_ok out.
module fetch_pc_gen
    import instr_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 64
) (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] next_pc,
    output logic        pc_ok,
    output logic        redir_ok
);

    logic redir_aligned;
    logic redir_in_rng;

    assign pc_ok         = pc_in_range(pc, RESET_PC, ROM_WORDS);
    assign redir_aligned = (redirect_pc[1:0] == 2'b00);
    assign redir_in_rng  = pc_in_range(redirect_pc, RESET_PC, ROM_WORDS);
    assign redir_ok      = redir_aligned && redir_in_rng;

    // Redirect wins over stall; wrap of pc+4 cannot be reached
    // because the range check halts the stage first.
    always_comb begin
        next_pc = pc + PC_INC;
        if (redirect) begin
            next_pc = redirect_pc;
        end else if (stall) begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: owns the PC, addresses the instruction ROM and registers
// the fetched word into IF/ID. Halts on bad redirect or PC overrun.
// Ports: clk, rst_n; imem_addr_o/imem_data_i to ROM; stall_i, flush_i,
// redirect_i, redirect_pc_i from hazard/branch logic; if_id_* to
// decode; halted_o, fetch_err_o status.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 64,
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic        if_id_valid_o,
    output logic        halted_o,
    output logic        fetch_err_o
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;

    logic [31:0] next_pc;
    logic        pc_ok;
    logic        redir_ok;

    fetch_pc_gen #(
        .RESET_PC  (RESET_PC),
        .ROM_WORDS (ROM_WORDS)
    ) u_pc_gen (
        .pc          (pc_q),
        .stall       (stall_i),
        .redirect    (redirect_i),
        .redirect_pc (redirect_pc_i),
        .next_pc     (next_pc),
        .pc_ok       (pc_ok),
        .redir_ok    (redir_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        err_d   = err_q;

        unique case (state_q)
            ST_BOOT: begin
                // One idle cycle so the ROM output settles on RESET_PC.
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_i) begin
                    // Wrong-path squash, even while stalled.
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    if (redir_ok) begin
                        pc_d = next_pc;
                    end else begin
                        state_d = ST_HALT;
                        err_d   = 1'b1;
                    end
                end else if (!pc_ok) begin
                    // Walked off the end of the ROM: no capture.
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = ST_HALT;
                    err_d   = 1'b1;
                end else if (flush_i) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    pc_d    = next_pc;
                end else if (!stall_i) begin
                    instr_d = imem_data_i;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = next_pc;
                end
            end
            ST_HALT: begin
                // Frozen until reset.
            end
            default: begin
                state_d = ST_HALT;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            ifpc_q   <= 32'h0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ifpc_q   <= ifpc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign if_id_instr_o = instr_q;
    assign if_id_pc_o    = ifpc_q;
    assign if_id_valid_o = valid_q;
    assign halted_o      = halted_q;
    assign fetch_err_o   = err_q;

endmodule
